// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and constants for the SRAM capture arbiter:
//               sequencer state encoding, grant-source encoding, CPU page.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  // Sequencer states for one SRAM access
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_WAIT   = 3'd1,
    ST_RD_LATCH  = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_STROBE = 3'd4,
    ST_WR_HOLD   = 3'd5
  } arb_state_t;

  // Owner of the access currently in flight
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_ADC  = 2'd2
  } grant_t;

  // A18..A16 used for every CPU access
  localparam logic [2:0] C_CPU_PAGE = 3'b000;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous DEPTH x 8 FIFO with first-word fall-through
//               output. A push while full is dropped unless a pop happens
//               in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign count = r_count;
  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign dout  = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_capture_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_capture_arbiter
// Description : Shares a 512Kx8 async SRAM between the 6502 bus and an ADC
//               capture stream. Samples are buffered in a FIFO and written to
//               a dedicated page; every strobe has setup/strobe/hold cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_capture_arbiter
  import sram_arb_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter int         HIGH_WATER = 6,
  parameter int         READ_WAIT  = 1,
  parameter logic [2:0] CAP_PAGE   = 3'b100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  input  logic        adc_valid,
  input  logic [7:0]  adc_data,
  input  logic        cap_start,
  input  logic [15:0] cap_base,
  input  logic [15:0] cap_len,
  output logic        cap_busy,
  output logic        cap_done,
  output logic        cap_overflow,
  output logic [18:0] sram_addr,
  output logic [7:0]  sram_dout,
  input  logic [7:0]  sram_din,
  output logic        sram_oe,
  output logic        sram_we
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CW-1:0] C_HIGH_WATER = CW'(HIGH_WATER);
  localparam logic [WW-1:0] C_WAIT_LAST  = WW'(READ_WAIT - 1);

  arb_state_t    r_state, w_state_nxt;
  grant_t        r_grant, w_grant_nxt;
  logic          r_last_hw;
  logic          w_hw_grant;
  logic          w_grant_go;
  logic [WW-1:0] r_wait_cnt;

  logic [CW-1:0] w_count;
  logic          w_full, w_empty, w_push, w_pop;
  logic [7:0]    w_fifo_dout;

  logic [15:0]   r_ptr, r_remaining;
  logic          r_busy, r_done, r_overflow;
  logic [18:0]   r_addr;
  logic [7:0]    r_dout, r_rdata;
  logic          r_ready;
  logic          w_start_ok, w_accept, w_adc_inflight, w_cap_finish;

  assign w_start_ok     = cap_start && !r_busy && (cap_len != 16'd0);
  // A sample arriving with an accepted start belongs to no capture
  assign w_accept       = adc_valid && (r_remaining != 16'd0) && !w_start_ok;
  assign w_push         = w_accept;
  assign w_pop          = (r_state == ST_WR_HOLD) && (r_grant == GNT_ADC);
  assign w_adc_inflight = (r_state != ST_IDLE) && (r_grant == GNT_ADC);
  assign w_cap_finish   = r_busy && (r_remaining == 16'd0) && w_empty && !w_adc_inflight;
  assign w_grant_go     = (r_state == ST_IDLE) && (w_grant_nxt != GNT_NONE);

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (adc_data),
    .dout  (w_fifo_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant decision and access sequencing; high-water ADC grants alternate with the CPU
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_hw_grant  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = GNT_NONE;
        if ((w_count >= C_HIGH_WATER) && !r_last_hw) begin
          w_grant_nxt = GNT_ADC;
          w_hw_grant  = 1'b1;
          w_state_nxt = ST_WR_SETUP;
        end else if (cpu_req && !r_ready) begin
          w_grant_nxt = GNT_CPU;
          w_state_nxt = cpu_we ? ST_WR_SETUP : ST_RD_WAIT;
        end else if (!w_empty) begin
          w_grant_nxt = GNT_ADC;
          w_state_nxt = ST_WR_SETUP;
        end
      end
      ST_RD_WAIT:   if (r_wait_cnt == C_WAIT_LAST) w_state_nxt = ST_RD_LATCH;
      ST_RD_LATCH:  w_state_nxt = ST_IDLE;
      ST_WR_SETUP:  w_state_nxt = ST_WR_STROBE;
      ST_WR_STROBE: w_state_nxt = ST_WR_HOLD;
      ST_WR_HOLD:   w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant bookkeeping, address/data launch at grant, read wait counter, CPU handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant    <= GNT_NONE;
      r_last_hw  <= 1'b0;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_dout     <= '0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_grant <= w_grant_nxt;
      if (w_grant_go) begin
        r_last_hw  <= w_hw_grant;
        r_wait_cnt <= '0;
        if (w_grant_nxt == GNT_ADC) begin
          r_addr <= {CAP_PAGE, r_ptr};
          r_dout <= w_fifo_dout;
        end else begin
          r_addr <= {C_CPU_PAGE, cpu_addr};
          r_dout <= cpu_wdata;
        end
      end else if (r_state == ST_RD_WAIT) begin
        r_wait_cnt <= r_wait_cnt + WW'(1);
      end
      if (r_state == ST_RD_LATCH) r_rdata <= sram_din;
      r_ready <= ((r_state == ST_RD_LATCH) || (r_state == ST_WR_HOLD)) && (r_grant == GNT_CPU);
    end
  end

  // Capture control: pointer, sample budget, busy/done and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_ok) begin
        r_ptr       <= cap_base;
        r_remaining <= cap_len;
        r_overflow  <= 1'b0;
        r_busy      <= 1'b1;
      end else begin
        if (w_grant_go && (w_grant_nxt == GNT_ADC)) r_ptr <= r_ptr + 16'd1;
        if (w_accept) begin
          r_remaining <= r_remaining - 16'd1;
          if (w_full && !w_pop) r_overflow <= 1'b1;
        end
        if (w_cap_finish) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  // Strobes decode straight from the state so an async reset drops them at once
  assign sram_we      = (r_state == ST_WR_STROBE);
  assign sram_oe      = (r_state == ST_WR_SETUP) || (r_state == ST_WR_STROBE) ||
                        (r_state == ST_WR_HOLD);
  assign sram_addr    = r_addr;
  assign sram_dout    = r_dout;
  assign cpu_rdata    = r_rdata;
  assign cpu_ready    = r_ready;
  assign cap_busy     = r_busy;
  assign cap_done     = r_done;
  assign cap_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sram_capture_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_capture_arbiter
// Description : Directed self-checking bench with an SRAM model and a write
//               scoreboard for sram_capture_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_capture_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        adc_valid;
  logic [7:0]  adc_data;
  logic        cap_start;
  logic [15:0] cap_base, cap_len;
  logic        cap_busy, cap_done, cap_overflow;
  logic [18:0] sram_addr;
  logic [7:0]  sram_dout, sram_din;
  logic        sram_oe, sram_we;

  int tests    = 0;
  int failures = 0;

  logic [7:0]  sram_mem [0:524287];
  logic [26:0] exp_q[$];
  logic [26:0] obs_q[$];
  int          we_run     = 0;
  int          we_max_run = 0;
  int          oe_viol    = 0;
  int          done_cnt   = 0;
  logic        prev_we    = 1'b0;

  sram_capture_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ready    (cpu_ready),
    .adc_valid    (adc_valid),
    .adc_data     (adc_data),
    .cap_start    (cap_start),
    .cap_base     (cap_base),
    .cap_len      (cap_len),
    .cap_busy     (cap_busy),
    .cap_done     (cap_done),
    .cap_overflow (cap_overflow),
    .sram_addr    (sram_addr),
    .sram_dout    (sram_dout),
    .sram_din     (sram_din),
    .sram_oe      (sram_oe),
    .sram_we      (sram_we)
  );

  always #5 clk = ~clk;

  assign sram_din = sram_mem[sram_addr];

  // SRAM model and write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (sram_we) begin
      sram_mem[sram_addr] = sram_dout;
      obs_q.push_back({sram_addr, sram_dout});
      we_run++;
      if (we_run > we_max_run) we_max_run = we_run;
    end else begin
      we_run = 0;
    end
    if (prev_we && !sram_we && !sram_oe) oe_viol++;
    prev_we = sram_we;
    if (cap_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                            output int lat, output logic [7:0] rd);
    @(negedge clk);
    while (cpu_ready) @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin lat = i; break; end
    end
    rd = cpu_rdata;
    cpu_req = 1'b0;
  endtask

  task automatic start_capture(input logic [15:0] base, input logic [15:0] len);
    @(negedge clk);
    cap_base = base; cap_len = len; cap_start = 1'b1;
    @(negedge clk);
    cap_start = 1'b0;
  endtask

  task automatic send_sample(input logic [7:0] d, input int gap);
    @(negedge clk);
    adc_valid = 1'b1; adc_data = d;
    @(negedge clk);
    adc_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && cap_busy; i++) @(negedge clk);
    check(tag, cap_busy, 1'b0);
  endtask

  task automatic sb_drain(input string tag);
    logic [26:0] e, o;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : 27'h7FFFFFF;
      check(tag, {5'd0, o}, {5'd0, e});
    end
    check({tag, "_extra"}, obs_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, n, dc0;
    logic [7:0]  rd;
    logic [26:0] w;

    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    adc_valid = 0; adc_data = 0; cap_start = 0; cap_base = 0; cap_len = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_addr", sram_addr, 0);
    check("rst_dout", sram_dout, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_strobes", {sram_we, sram_oe, cpu_ready}, 0);
    check("rst_cap", {cap_busy, cap_done, cap_overflow}, 0);

    // CPU write / read-back with latency
    exp_q.push_back({19'h01234, 8'h5A});
    exp_q.push_back({19'h000FF, 8'hC3});
    cpu_access(1'b1, 16'h1234, 8'h5A, lat, rd);
    check("wr_latency", lat, 4);
    cpu_access(1'b1, 16'h00FF, 8'hC3, lat, rd);
    check("wr2_latency", lat, 4);
    cpu_access(1'b0, 16'h1234, 8'h00, lat, rd);
    check("rd_latency", lat, 3);
    check("rd_data", rd, 8'h5A);
    cpu_access(1'b0, 16'h00FF, 8'h00, lat, rd);
    check("rd2_data", rd, 8'hC3);
    sb_drain("cpu_wr");

    // Capture wrapping within the page
    dc0 = done_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back({3'b100, 16'hFFFE + 16'(i), 8'h11 + 8'(i)});
    start_capture(16'hFFFE, 16'd4);
    check("cap_busy_set", cap_busy, 1'b1);
    for (int i = 0; i < 4; i++) send_sample(8'h11 + 8'(i), 4);
    wait_idle("cap_wrap_idle");
    repeat (2) @(negedge clk);
    check("cap_done_once", done_cnt - dc0, 1);
    check("cap_wrap_ovf", cap_overflow, 1'b0);
    sb_drain("cap_wrap");

    // Samples every cycle overflow the FIFO
    start_capture(16'h0200, 16'd16);
    @(negedge clk); adc_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      adc_data = 8'h50 + 8'(i);
      @(negedge clk);
    end
    adc_valid = 1'b0;
    wait_idle("ovf_idle");
    check("ovf_flag", cap_overflow, 1'b1);
    n = obs_q.size();
    check("ovf_fewer", (n < 16) && (n >= 8), 1'b1);
    for (int i = 0; i < n; i++) begin
      w = obs_q.pop_front();
      check("ovf_addr", w[26:8], 19'h40200 + 19'(i));
      if (i == 0) check("ovf_first", w[7:0], 8'h50);
    end
    start_capture(16'h0000, 16'd1);
    check("ovf_cleared", cap_overflow, 1'b0);
    exp_q.push_back({19'h40000, 8'h99});
    send_sample(8'h99, 2);
    wait_idle("ovf2_idle");
    sb_drain("ovf2");

    // Back-to-back CPU reads while samples arrive every 5 cycles
    for (int i = 0; i < 12; i++) exp_q.push_back({19'h40100 + 19'(i), 8'h30 + 8'(i)});
    start_capture(16'h0100, 16'd12);
    fork
      begin
        for (int i = 0; i < 12; i++) send_sample(8'h30 + 8'(i), 3);
      end
      begin
        for (int j = 0; j < 12; j++) begin
          int         l;
          logic [7:0] r;
          cpu_access(1'b0, j[0] ? 16'h00FF : 16'h1234, 8'h00, l, r);
          check("b2b_done", l > 0, 1'b1);
          check("b2b_data", r, j[0] ? 8'hC3 : 8'h5A);
        end
      end
    join
    wait_idle("b2b_idle");
    check("b2b_ovf", cap_overflow, 1'b0);
    sb_drain("b2b_cap");

    // A sample coinciding with cap_start is not captured
    @(negedge clk);
    cap_base = 16'h0300; cap_len = 16'd1; cap_start = 1'b1;
    adc_valid = 1'b1; adc_data = 8'hAA;
    @(negedge clk);
    cap_start = 1'b0; adc_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back({19'h40300, 8'h77});
    send_sample(8'h77, 2);
    wait_idle("coinc_idle");
    sb_drain("coinc");

    // Reset in the middle of a write strobe
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 8'hEE;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sram_we) break;
    end
    check("mid_we_seen", sram_we, 1'b1);
    reset = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("mid_rst_strobes", {sram_we, sram_oe}, 2'b00);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_outs", {sram_addr, sram_dout, cpu_rdata}, 0);
    check("post_rst_cap", {cap_busy, cap_done, cap_overflow}, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (cpu_ready) n++;
    end
    check("post_rst_ready", n, 0);
    check("post_rst_nowrite", obs_q.size(), 0);

    check("we_one_cycle", we_max_run, 1);
    check("oe_hold", oe_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
`default_nettype wire
